// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-side front end.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {LD_LOAD, LD_RUN} ld_state_e;
endpackage

// File: rtl/imem_array.sv
// Instruction store: one synchronous write port, one asynchronous read port, no reset.
module imem_array
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_mem_loader.sv
// Program-load sequencer and zero-latency instruction fetch for the single-cycle core.
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int                 DEPTH_WORDS = 1024,
  parameter logic [INSTR_W-1:0] NOP_WORD    = mips_pkg::NOP_WORD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en_ins,
  input  logic [INSTR_W-1:0]          wr_data,
  input  logic                        load_done,
  input  logic [31:0]                 pc,
  output logic                        load_ready,
  output logic                        core_run,
  output logic [INSTR_W-1:0]          INSTRUCTION,
  output logic [$clog2(DEPTH_WORDS):0] load_count,
  output logic                        fetch_fault,
  output logic                        load_err
);
  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH_WORDS);

  ld_state_e          state;
  logic               we;
  logic [ADDR_W-1:0]  idx;
  logic [INSTR_W-1:0] rdata;
  logic               fetch_ok;

  assign load_ready = (state == LD_LOAD) && (load_count < FULL);
  assign we         = (state == LD_LOAD) && wr_en_ins && load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LD_LOAD;
      load_count <= '0;
      core_run   <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      case (state)
        LD_LOAD: begin
          if (we) load_count <= load_count + 1'b1;
          if (wr_en_ins && !load_ready) load_err <= 1'b1;
          // The word presented alongside load_done is still taken above.
          if (load_done) begin
            state    <= LD_RUN;
            core_run <= 1'b1;
          end
        end
        LD_RUN: begin
          if (wr_en_ins) load_err <= 1'b1;
        end
        default: state <= LD_LOAD;
      endcase
    end
  end

  imem_array #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (load_count[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (idx),
    .rdata (rdata)
  );

  // Anything past the loaded image reads as NOP rather than wrapping into stale data.
  assign idx      = pc[ADDR_W+1:2];
  assign fetch_ok = (state == LD_RUN) && (pc[1:0] == 2'b00) &&
                    (pc[31:ADDR_W+2] == '0) && ({1'b0, idx} < load_count);

  assign INSTRUCTION = fetch_ok ? rdata : NOP_WORD;
  assign fetch_fault = (state == LD_RUN) && !fetch_ok;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: directed load/fetch sequences with hand-computed expectations.
module tb_instr_mem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en_ins = 1'b0;
  logic [31:0] wr_data = '0;
  logic        load_done = 1'b0;
  logic [31:0] pc = '0;
  logic        load_ready, core_run, fetch_fault, load_err;
  logic [31:0] INSTRUCTION;
  logic [10:0] load_count;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        fault;
    logic        run;
    logic        ready;
    logic        err;
    logic [10:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;

  instr_mem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en_ins   (wr_en_ins),
    .wr_data     (wr_data),
    .load_done   (load_done),
    .pc          (pc),
    .load_ready  (load_ready),
    .core_run    (core_run),
    .INSTRUCTION (INSTRUCTION),
    .load_count  (load_count),
    .fetch_fault (fetch_fault),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable mid-cycle, compare everything queued for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_total++;
      if (INSTRUCTION === e.instr && fetch_fault === e.fault && core_run === e.run &&
          load_ready === e.ready && load_err === e.err && load_count === e.cnt)
        n_pass++;
      else
        $display("FAIL %s: got instr=%h fault=%b run=%b ready=%b err=%b cnt=%0d, want instr=%h fault=%b run=%b ready=%b err=%b cnt=%0d",
                 e.name, INSTRUCTION, fetch_fault, core_run, load_ready, load_err, load_count,
                 e.instr, e.fault, e.run, e.ready, e.err, e.cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] a, input logic [31:0] instr,
                            input logic fault, input logic run, input logic ready,
                            input logic err, input int cnt);
    exp_t e;
    pc = a;
    e.name = name; e.instr = instr; e.fault = fault; e.run = run;
    e.ready = ready; e.err = err; e.cnt = 11'(cnt);
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en_ins = 1'b0; load_done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] d, input logic done);
    wr_en_ins = 1'b1; wr_data = d; load_done = done;
    step();
    wr_en_ins = 1'b0; load_done = 1'b0;
  endtask

  task automatic finish_load();
    load_done = 1'b1;
    step();
    load_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Basic 3-word image
    do_reset();
    expect_out("reset_state", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    write_word(32'h2008_0005, 1'b0);
    expect_out("load_fetch_held", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    write_word(32'h2009_0007, 1'b0);
    write_word(32'h0109_5020, 1'b0);
    finish_load();
    expect_out("run_pc0", 32'h0, 32'h2008_0005, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    expect_out("run_pc4", 32'h4, 32'h2009_0007, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    expect_out("run_pc8", 32'h8, 32'h0109_5020, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    expect_out("past_end", 32'hC, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    expect_out("misaligned", 32'h2, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    expect_out("out_of_range", 32'h1000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    load_done = 1'b1;
    expect_out("load_done_ignored", 32'h4, 32'h2009_0007, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    load_done = 1'b0;

    // Fill to capacity, then overflow
    do_reset();
    for (int i = 0; i < 1024; i++) write_word(32'hA000_0000 + 32'(i), 1'b0);
    expect_out("full_not_ready", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1024);
    write_word(32'hDEAD_BEEF, 1'b0);
    expect_out("overflow_err", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1024);
    finish_load();
    expect_out("full_last_word", 32'hFFC, 32'hA000_03FF, 1'b0, 1'b1, 1'b0, 1'b1, 1024);
    expect_out("full_first_word", 32'h0, 32'hA000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1024);

    // Write together with load_done, then write in RUN
    do_reset();
    write_word(32'h1111_1111, 1'b0);
    write_word(32'h2222_2222, 1'b1);
    expect_out("wr_with_done", 32'h4, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    write_word(32'hBAD0_BAD0, 1'b0);
    expect_out("run_write_err", 32'h0, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b1, 2);
    expect_out("run_write_no_grow", 32'h8, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2);

    // Reset mid-RUN, reload a single word over stale data
    pc = 32'h8;
    do_reset();
    expect_out("reset_from_run", 32'h8, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    write_word(32'h1234_5678, 1'b0);
    finish_load();
    expect_out("reload_pc0", 32'h0, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    expect_out("reload_stale", 32'h4, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1);

    // Empty image
    do_reset();
    finish_load();
    expect_out("empty_pc0", 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    expect_out("empty_pcffc", 32'hFFC, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
